wb_stage_buffered: RTL and testbench

- Parametrised write-back stage for the ARM pipeline.
- Selects ALU result or load data, and extracts and extends byte/halfword loads.
- Queues completed results in a DEPTH-entry FIFO in front of the register-file write port, which may stall via rf_ready.
- Reports pending destinations to the hazard unit so reads of not-yet-written registers are held off.

---
 rtl/wb_stage_if.sv | 38 +++
 rtl/wb_stage_buffered.sv | 103 ++++++++++
 tb/tb_wb_stage_buffered.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Write-back stage bus: MEM-stage inputs, register-file write port, hazard query.
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int DEPTH  = 2
);
    logic                       in_valid;
    logic                       in_ready;
    logic                       wb_en_in;
    logic                       mem_r_en;
    logic [DATA_W-1:0]          alu_res;
    logic [DATA_W-1:0]          mem_data;
    logic [1:0]                 mem_size;
    logic                       mem_signed;
    logic [1:0]                 byte_off;
    logic [DEST_W-1:0]          dest_in;
    logic                       rf_ready;
    logic                       wb_en_out;
    logic [DEST_W-1:0]          wb_dest;
    logic [DATA_W-1:0]          wb_value;
    logic [DEST_W-1:0]          hz_src1;
    logic [DEST_W-1:0]          hz_src2;
    logic                       hz_hit1;
    logic                       hz_hit2;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output in_valid, wb_en_in, mem_r_en, alu_res, mem_data, mem_size,
               mem_signed, byte_off, dest_in, rf_ready, hz_src1, hz_src2,
        input  in_ready, wb_en_out, wb_dest, wb_value, hz_hit1, hz_hit2, count
    );

    modport slave (
        input  in_valid, wb_en_in, mem_r_en, alu_res, mem_data, mem_size,
               mem_signed, byte_off, dest_in, rf_ready, hz_src1, hz_src2,
        output in_ready, wb_en_out, wb_dest, wb_value, hz_hit1, hz_hit2, count
    );
endinterface

// File: rtl/wb_stage_buffered.sv
// Write-back stage: load extract/extend, DEPTH-entry queue to the register file; 1-cycle min latency.
// Backpressure: rf_ready holds the head; in_ready drops only when full (independent of rf_ready).
module wb_stage_buffered #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_stage_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [DEPTH-1:0]  occ;
    logic [DEST_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] val_q  [DEPTH];

    logic [7:0]        b_lane;
    logic [15:0]       h_lane;
    logic [DATA_W-1:0] ld_val;
    logic [DATA_W-1:0] in_val;
    logic              ready;
    logic              head_vld;
    logic              push;
    logic              pop;
    logic              hit1;
    logic              hit2;

    assign ready    = (cnt < CNT_W'(DEPTH));
    assign head_vld = (cnt != '0);
    assign push     = bus.in_valid & ready & bus.wb_en_in;
    assign pop      = head_vld & bus.rf_ready;

    always_comb begin
        b_lane = bus.mem_data[7:0];
        case (bus.byte_off)
            2'd1:    b_lane = bus.mem_data[15:8];
            2'd2:    b_lane = bus.mem_data[23:16];
            2'd3:    b_lane = bus.mem_data[31:24];
            default: b_lane = bus.mem_data[7:0];
        endcase
        // Halfword lane picks on byte_off[1] only; misaligned bit 0 is ignored.
        h_lane = bus.byte_off[1] ? bus.mem_data[31:16] : bus.mem_data[15:0];
        case (bus.mem_size)
            2'b01:   ld_val = {{(DATA_W-16){bus.mem_signed & h_lane[15]}}, h_lane};
            2'b10:   ld_val = {{(DATA_W-8){bus.mem_signed & b_lane[7]}}, b_lane};
            default: ld_val = bus.mem_data;
        endcase
        in_val = bus.mem_r_en ? ld_val : bus.alu_res;
    end

    // Push and pop never target the same slot: that needs count 0 (no pop) or full (no push).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                occ[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                occ[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wr_ptr] <= bus.dest_in;
            val_q[wr_ptr]  <= in_val;
        end
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && (dest_q[i] == bus.hz_src1)) hit1 = 1'b1;
            if (occ[i] && (dest_q[i] == bus.hz_src2)) hit2 = 1'b1;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.wb_en_out = head_vld;
    assign bus.wb_dest   = head_vld ? dest_q[rd_ptr] : '0;
    assign bus.wb_value  = head_vld ? val_q[rd_ptr]  : '0;
    assign bus.hz_hit1   = hit1;
    assign bus.hz_hit2   = hit2;
    assign bus.count     = cnt;
endmodule

// File: tb/tb_wb_stage_buffered.sv
// Directed bench for wb_stage_buffered with a write-back scoreboard.
module tb_wb_stage_buffered;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_stage_if #(.DATA_W(32), .DEST_W(4), .DEPTH(2)) bus();

    wb_stage_buffered #(.DATA_W(32), .DEST_W(4), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  dest;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t cur_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Record the expected write whenever a writing transfer is about to be accepted.
    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready && bus.wb_en_in)
            sb.push_back(cur_exp);
    end

    // Compare every register-file write against the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && bus.wb_en_out && bus.rf_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got dest %0d value %0h expected none", bus.wb_dest, bus.wb_value);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_dest", 64'(bus.wb_dest), 64'(e.dest));
                check("wb_value", 64'(bus.wb_value), 64'(e.val));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic mr, input logic [31:0] alu,
                        input logic [31:0] md, input logic [1:0] sz, input logic sg,
                        input logic [1:0] off, input logic [3:0] d, input logic [31:0] ev);
        bit acc;
        bus.in_valid   = 1'b1;
        bus.wb_en_in   = we;
        bus.mem_r_en   = mr;
        bus.alu_res    = alu;
        bus.mem_data   = md;
        bus.mem_size   = sz;
        bus.mem_signed = sg;
        bus.byte_off   = off;
        bus.dest_in    = d;
        cur_exp        = '{dest: d, val: ev};
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept of dest %0d", d);
        end
        bus.in_valid = 1'b0;
    endtask

    localparam logic [31:0] MD = 32'h80F17F02;

    initial begin
        bus.in_valid = 0; bus.wb_en_in = 0; bus.mem_r_en = 0; bus.alu_res = 0;
        bus.mem_data = 0; bus.mem_size = 0; bus.mem_signed = 0; bus.byte_off = 0;
        bus.dest_in = 0; bus.rf_ready = 0; bus.hz_src1 = 0; bus.hz_src2 = 0;
        cur_exp = '0;
        #2;
        check("rst_in_ready", 64'(bus.in_ready), 1);
        check("rst_count", 64'(bus.count), 0);
        check("rst_wb_en_out", 64'(bus.wb_en_out), 0);
        check("rst_wb_dest", 64'(bus.wb_dest), 0);
        check("rst_wb_value", 64'(bus.wb_value), 0);
        check("rst_hz_hit1", 64'(bus.hz_hit1), 0);
        check("rst_hz_hit2", 64'(bus.hz_hit2), 0);
        #10 rst_n = 1'b1;
        step();

        // ALU result path
        bus.rf_ready = 1'b1;
        send(1, 0, 32'h12345678, 32'hDEADBEEF, 2'b10, 1, 2'd3, 4'd3, 32'h12345678);
        check("alu_wb_en_out", 64'(bus.wb_en_out), 1);
        check("alu_wb_dest", 64'(bus.wb_dest), 3);
        check("alu_wb_value", 64'(bus.wb_value), 64'h12345678);
        step();
        check("alu_drain_en", 64'(bus.wb_en_out), 0);
        check("alu_drain_count", 64'(bus.count), 0);

        // Load extraction, back to back with rf_ready high
        send(1, 1, 32'h0, MD, 2'b10, 1, 2'd1, 4'd4, 32'h0000007F);
        send(1, 1, 32'h0, MD, 2'b10, 1, 2'd3, 4'd5, 32'hFFFFFF80);
        send(1, 1, 32'h0, MD, 2'b01, 0, 2'd2, 4'd6, 32'h000080F1);
        send(1, 1, 32'h0, MD, 2'b01, 1, 2'd0, 4'd7, 32'h00007F02);
        send(1, 1, 32'h0, MD, 2'b00, 1, 2'd2, 4'd8, 32'h80F17F02);
        send(1, 1, 32'h0, MD, 2'b10, 0, 2'd2, 4'd9, 32'h000000F1);
        send(1, 1, 32'h0, MD, 2'b01, 1, 2'd3, 4'd10, 32'hFFFF80F1);
        send(1, 1, 32'h0, MD, 2'b11, 1, 2'd1, 4'd11, 32'h80F17F02);
        step();
        check("load_drain_count", 64'(bus.count), 0);

        // Backpressure: fill with rf_ready low
        bus.rf_ready = 1'b0;
        send(1, 0, 32'h11, 32'h0, 2'b00, 0, 2'd0, 4'd1, 32'h11);
        send(1, 0, 32'h22, 32'h0, 2'b00, 0, 2'd0, 4'd2, 32'h22);
        check("full_count", 64'(bus.count), 2);
        check("full_in_ready", 64'(bus.in_ready), 0);
        bus.in_valid = 1'b1; bus.wb_en_in = 1'b1; bus.mem_r_en = 1'b0;
        bus.alu_res = 32'h77; bus.dest_in = 4'd7;
        cur_exp = '{dest: 4'd7, val: 32'h77};
        @(negedge clk);
        check("full_hold_in_ready", 64'(bus.in_ready), 0);
        check("full_hold_head", 64'(bus.wb_dest), 1);
        step();
        @(negedge clk);
        check("full_hold_count", 64'(bus.count), 2);
        check("full_hold_head2", 64'(bus.wb_dest), 1);
        step();
        // Full with simultaneous pop: no push this cycle, push on the next
        bus.rf_ready = 1'b1;
        step();
        check("pop_full_count", 64'(bus.count), 1);
        check("pop_full_head", 64'(bus.wb_dest), 2);
        step();
        bus.in_valid = 1'b0;
        check("pushpop_count", 64'(bus.count), 1);
        check("pushpop_head", 64'(bus.wb_dest), 7);
        step();
        check("pushpop_drain", 64'(bus.count), 0);

        // Dropped transfer
        send(0, 0, 32'h99, 32'h0, 2'b00, 0, 2'd0, 4'd9, 32'h99);
        check("drop_count", 64'(bus.count), 0);
        check("drop_wb_en_out", 64'(bus.wb_en_out), 0);

        // Hazard query
        bus.rf_ready = 1'b0;
        send(1, 0, 32'h55, 32'h0, 2'b00, 0, 2'd0, 4'd5, 32'h55);
        bus.hz_src1 = 4'd5; bus.hz_src2 = 4'd6;
        #1;
        check("hz_hit1_queued", 64'(bus.hz_hit1), 1);
        check("hz_hit2_other", 64'(bus.hz_hit2), 0);
        bus.hz_src2 = 4'd5;
        #1;
        check("hz_hit2_queued", 64'(bus.hz_hit2), 1);
        bus.hz_src2 = 4'd6;
        step();
        bus.rf_ready = 1'b1;
        @(negedge clk);
        check("hz_hit1_retiring", 64'(bus.hz_hit1), 1);
        step();
        check("hz_hit1_after", 64'(bus.hz_hit1), 0);

        // Asynchronous reset with two entries queued
        bus.rf_ready = 1'b0;
        send(1, 0, 32'hA0, 32'h0, 2'b00, 0, 2'd0, 4'd10, 32'hA0);
        send(1, 0, 32'hB0, 32'h0, 2'b00, 0, 2'd0, 4'd11, 32'hB0);
        bus.hz_src1 = 4'd10;
        check("pre_rst_count", 64'(bus.count), 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 64'(bus.count), 0);
        check("arst_wb_en_out", 64'(bus.wb_en_out), 0);
        check("arst_wb_dest", 64'(bus.wb_dest), 0);
        check("arst_wb_value", 64'(bus.wb_value), 0);
        check("arst_in_ready", 64'(bus.in_ready), 1);
        check("arst_hz_hit1", 64'(bus.hz_hit1), 0);
        sb.delete();
        bus.rf_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_write", 64'(bus.wb_en_out), 0);
        end
        step();
        send(1, 0, 32'hC0FFEE, 32'h0, 2'b00, 0, 2'd0, 4'd12, 32'hC0FFEE);
        step();
        step();
        check("sb_empty", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
